// File: rtl/decoder_2x4_stream.sv
// Registered, handshaked W-to-2^W one-hot decoder with a 2-entry in-order
// output buffer and a saturating count of accepted codes.
//
// state | meaning
// EMPTY | no entry buffered, out_valid=0
// ONE   | head holds the entry being presented
// TWO   | head presented, tail queued behind it, input stalled
module decoder_2x4_stream #(
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<W)-1:0]     out_onehot,
  output logic [W-1:0]          out_code,
  output logic [CNT_W-1:0]      dec_count,
  input  logic                  cnt_clr
);

  localparam int OW = 1 << W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] head, head_d;
  logic [W-1:0] tail, tail_d;
  logic         accept;
  logic         pop;

  // in_ready looks only at registered occupancy; rst_n keeps it low while held in reset
  assign in_ready  = en & rst_n & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_d;
      head  <= head_d;
      tail  <= tail_d;
    end
  end

  always_comb begin
    state_d = state;
    head_d  = head;
    tail_d  = tail;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = in_code;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_code;
        end else if (accept) begin
          state_d = TWO;
          tail_d  = in_code;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_onehot = '0;
    out_code   = '0;
    if (out_valid) begin
      out_onehot[head] = 1'b1;
      out_code         = head;
    end
  end

  // clear takes priority over a same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count <= '0;
    end else if (cnt_clr) begin
      dec_count <= '0;
    end else if (accept && (dec_count != CNT_MAX)) begin
      dec_count <= dec_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_2x4_stream.sv
// Self-checking bench for decoder_2x4_stream: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_decoder_2x4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_onehot;
  logic [1:0] out_code;
  logic [7:0] dec_count;
  logic       cnt_clr;

  int total = 0;
  int bad   = 0;

  int q[$];
  int mcnt = 0;

  always #5 clk = ~clk;

  decoder_2x4_stream #(.W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_code   (out_code),
    .dec_count  (dec_count),
    .cnt_clr    (cnt_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int exp_oh;
    int exp_code;
    exp_oh   = (q.size() > 0) ? (1 << q[0]) : 0;
    exp_code = (q.size() > 0) ? q[0] : 0;
    check("model_out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
    check("model_out_onehot", int'(out_onehot), exp_oh);
    check("model_out_code", int'(out_code), exp_code);
    check("model_in_ready", int'(in_ready), (en && q.size() < 2) ? 1 : 0);
    check("model_dec_count", int'(dec_count), mcnt);
  endtask

  // One cycle: drive at negedge, compare, then advance model across the edge.
  task automatic step(input logic e, input logic iv, input int c,
                      input logic ordy, input logic clr);
    bit acc;
    bit pp;
    @(negedge clk);
    en        = e;
    in_valid  = iv;
    in_code   = c[1:0];
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    compare_model();
    acc = iv && e && (q.size() < 2);
    pp  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(c & 3);
    if (clr) mcnt = 0;
    else if (acc && mcnt < 255) mcnt++;
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    mcnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_onehot"}, int'(out_onehot), 0);
    check({tag, "_out_code"}, int'(out_code), 0);
    check({tag, "_dec_count"}, int'(dec_count), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 2'd0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    model_reset();

    // 1: reset then stream 0..3
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, i, 1, 0);
      check("s1_onehot", int'(out_onehot), 1 << i);
      check("s1_in_ready", int'(in_ready), 1);
    end
    step(1, 0, 0, 1, 0);
    check("s1_count", int'(dec_count), 4);
    check("s1_drained", int'(out_valid), 0);

    // 2: back-pressure fill to TWO
    step(1, 1, 3, 0, 0);
    step(1, 1, 1, 0, 0);
    check("s2_in_ready", int'(in_ready), 0);
    check("s2_hold", int'(out_onehot), 8);

    // 3: en=0 blocks accepts; buffered entries still drain
    for (int i = 0; i < 5; i++) step(0, 1, 2, 0, 0);
    check("s3_count", int'(dec_count), 6);
    check("s3_hold", int'(out_onehot), 8);
    step(0, 1, 2, 1, 0);
    check("s3_drain1", int'(out_onehot), 2);
    step(0, 1, 2, 1, 0);
    check("s3_drain_empty", int'(out_valid), 0);
    step(1, 1, 2, 1, 0);
    check("s3_third", int'(out_onehot), 4);
    step(1, 0, 0, 1, 0);

    // 4: saturation and clear-vs-accept
    for (int i = 0; i < 260; i++) step(1, 1, $urandom_range(0, 3), 1, 0);
    check("s4_sat", int'(dec_count), 255);
    step(1, 1, 1, 1, 0);
    check("s4_sat_hold", int'(dec_count), 255);
    step(1, 1, 2, 1, 1);
    check("s4_clr", int'(dec_count), 0);
    step(1, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 3),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));

    // 5: async reset from TWO between edges
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 2, 0, 0);
    step(1, 1, 3, 0, 0);
    check("s5_full", int'(in_ready), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s5_async");
    model_reset();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 1, 0, 0);
    check("s5_first", int'(out_onehot), 2);
    check("s5_count", int'(dec_count), 1);
    step(1, 0, 0, 1, 0);
    check("s5_no_stale", int'(out_valid), 0);

    // 6: simultaneous accept/pop in ONE
    step(1, 1, 0, 0, 0);
    check("s6_head0", int'(out_onehot), 1);
    step(1, 1, 3, 1, 0);
    check("s6_swap", int'(out_onehot), 8);
    check("s6_ready", int'(in_ready), 1);
    step(1, 0, 0, 1, 0);
    check("s6_empty", int'(out_valid), 0);
    step(1, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
